// File: rtl/frog_pkg.sv
// Constants and direction encoding shared by the frog mover, renderer and VGA timing block.
package frog_pkg;

    localparam int GRID_SIZE = 32;
    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    // Bit positions of the per-direction pending flags.
    localparam int PEND_UP    = 0;
    localparam int PEND_DOWN  = 1;
    localparam int PEND_LEFT  = 2;
    localparam int PEND_RIGHT = 3;

    function automatic dir_t pick_dir(input logic [3:0] pend);
        if (pend[PEND_UP]) begin
            return DIR_UP;
        end else if (pend[PEND_DOWN]) begin
            return DIR_DOWN;
        end else if (pend[PEND_LEFT]) begin
            return DIR_LEFT;
        end else if (pend[PEND_RIGHT]) begin
            return DIR_RIGHT;
        end else begin
            return DIR_NONE;
        end
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button conditioner: 2-flop synchroniser, stability counter and
// rising-edge detector producing a single-cycle registered press pulse.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0_q, sync1_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised level disagrees with the committed one,
    // so any bounce back to the committed level restarts the count from zero.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync1_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync1_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        press_d = level_d & ~level_q;
    end

    // Synchroniser, debounce state and press pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync0_q <= btn_i;
            sync1_q <= sync0_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/frog_mover.sv
// Frog position register: queues one hop per frame from debounced buttons and applies it on frame_tick.
// Optional FROG_WRAP_EN makes horizontal hops wrap around the screen edges.
import frog_pkg::*;

module frog_mover #(
    parameter int GRID_SIZE       = frog_pkg::GRID_SIZE,
    parameter int H_VISIBLE       = frog_pkg::H_VISIBLE,
    parameter int V_VISIBLE       = frog_pkg::V_VISIBLE,
    parameter int START_X         = 320,
    parameter int START_Y         = 448,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       frame_tick,
    input  logic       respawn,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic       moved,
    output logic       at_goal
);

    localparam logic signed [10:0] GRID_S = 11'(GRID_SIZE);
    localparam logic signed [10:0] MAX_X  = 11'(H_VISIBLE - GRID_SIZE);
    localparam logic signed [10:0] MAX_Y  = 11'(V_VISIBLE - GRID_SIZE);
    localparam logic signed [10:0] ZERO_S = 11'sd0;

    logic [3:0]        press_s;
    logic [3:0]        pend_q, pend_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic              moved_q, moved_d;
    logic signed [10:0] cur_x_s, cur_y_s, nx_s, ny_s;
    logic              hop_ok_s;
    dir_t              sel_s;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .rst(rst), .btn_i(btn_up), .press_o(press_s[PEND_UP])
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .rst(rst), .btn_i(btn_down), .press_o(press_s[PEND_DOWN])
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(clk), .rst(rst), .btn_i(btn_left), .press_o(press_s[PEND_LEFT])
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(clk), .rst(rst), .btn_i(btn_right), .press_o(press_s[PEND_RIGHT])
    );

    // Candidate position for the highest-priority pending hop and whether it is legal.
    always_comb begin
        cur_x_s  = signed'({1'b0, x_q});
        cur_y_s  = signed'({1'b0, y_q});
        sel_s    = pick_dir(pend_q);
        nx_s     = cur_x_s;
        ny_s     = cur_y_s;
        hop_ok_s = 1'b0;
        case (sel_s)
            DIR_UP: begin
                ny_s     = cur_y_s - GRID_S;
                hop_ok_s = (ny_s >= ZERO_S);
            end
            DIR_DOWN: begin
                ny_s     = cur_y_s + GRID_S;
                hop_ok_s = (ny_s <= MAX_Y);
            end
            DIR_LEFT: begin
`ifdef FROG_WRAP_EN
                nx_s     = ((cur_x_s - GRID_S) < ZERO_S) ? MAX_X : (cur_x_s - GRID_S);
                hop_ok_s = 1'b1;
`else
                nx_s     = cur_x_s - GRID_S;
                hop_ok_s = (nx_s >= ZERO_S);
`endif
            end
            DIR_RIGHT: begin
`ifdef FROG_WRAP_EN
                nx_s     = ((cur_x_s + GRID_S) > MAX_X) ? ZERO_S : (cur_x_s + GRID_S);
                hop_ok_s = 1'b1;
`else
                nx_s     = cur_x_s + GRID_S;
                hop_ok_s = (nx_s <= MAX_X);
`endif
            end
            default: begin
                hop_ok_s = 1'b0;
            end
        endcase
    end

    // Respawn beats frame_tick; presses landing on the tick cycle survive into the next frame.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        moved_d = 1'b0;
        pend_d  = pend_q | press_s;
        if (respawn) begin
            x_d    = 10'(START_X);
            y_d    = 10'(START_Y);
            pend_d = 4'b0000;
        end else if (frame_tick) begin
            pend_d = press_s;
            if (hop_ok_s) begin
                x_d     = nx_s[9:0];
                y_d     = ny_s[9:0];
                moved_d = 1'b1;
            end else begin
                moved_d = 1'b0;
            end
        end else begin
            pend_d = pend_q | press_s;
        end
    end

    // Position, pending and moved registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= 10'(START_X);
            y_q     <= 10'(START_Y);
            moved_q <= 1'b0;
            pend_q  <= 4'b0000;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            moved_q <= moved_d;
            pend_q  <= pend_d;
        end
    end

    assign frog_x  = x_q;
    assign frog_y  = y_q;
    assign moved   = moved_q;
    assign at_goal = (y_q == 10'd0);

endmodule

// File: tb/tb_frog_mover.sv
// Self-checking bench for frog_mover with a short debounce window.
module tb_frog_mover;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       frame_tick = 1'b0;
    logic       respawn = 1'b0;
    logic [9:0] frog_x, frog_y;
    logic       moved, at_goal;

    frog_mover #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .frame_tick(frame_tick), .respawn(respawn),
        .frog_x(frog_x), .frog_y(frog_y), .moved(moved), .at_goal(at_goal)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] B_UP = 4'b1000, B_DOWN = 4'b0100, B_LEFT = 4'b0010, B_RIGHT = 4'b0001;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       mv;
    } exp_t;

    typedef struct {
        logic [3:0] btn;
        logic       rsp;
        logic [9:0] x;
        logic [9:0] y;
        logic       mv;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input logic [3:0] m);
        {btn_up, btn_down, btn_left, btn_right} = m;
    endtask

    task automatic press(input logic [3:0] m);
        set_btn(m);
        cycles(12);
        set_btn(4'b0000);
        cycles(12);
    endtask

    // Drive one tick (optionally with respawn) from a negedge, check the cycle after, and moved dropping.
    task automatic tick(input logic rsp, input logic [9:0] ex, input logic [9:0] ey,
                        input logic emv, input string nm);
        exp_t e;
        exp_t g;
        e.x = ex; e.y = ey; e.mv = emv;
        frame_tick = 1'b1;
        respawn    = rsp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        respawn    = 1'b0;
        g = sb.pop_front();
        chk({nm, "_x"}, 16'(frog_x), 16'(g.x));
        chk({nm, "_y"}, 16'(frog_y), 16'(g.y));
        chk({nm, "_moved"}, 16'(moved), 16'(g.mv));
        @(posedge clk);
        #1;
        chk({nm, "_moved_drop"}, 16'(moved), 16'd0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic wrap;
`ifdef FROG_WRAP_EN
        wrap = 1'b1;
`else
        wrap = 1'b0;
`endif
        // Reset state
        cycles(3);
        chk("rst_x", 16'(frog_x), 16'd320);
        chk("rst_y", 16'(frog_y), 16'd448);
        chk("rst_moved", 16'(moved), 16'd0);
        chk("rst_goal", 16'(at_goal), 16'd0);
        rst = 1'b0;
        cycles(2);

        for (int i = 0; i < 10; i++) tick(1'b0, 10'd320, 10'd448, 1'b0, "idle");

        // Held button: one hop, then nothing on the next tick
        set_btn(B_UP);
        cycles(20);
        tick(1'b0, 10'd320, 10'd416, 1'b1, "hold1");
        tick(1'b0, 10'd320, 10'd416, 1'b0, "hold2");
        set_btn(4'b0000);
        cycles(12);

        // Bouncing button settles to a single hop
        for (int i = 0; i < 6; i++) begin
            btn_up = (i % 2 == 0);
            cycles(2);
        end
        btn_up = 1'b1;
        cycles(12);
        tick(1'b0, 10'd320, 10'd384, 1'b1, "bounce1");
        tick(1'b0, 10'd320, 10'd384, 1'b0, "bounce2");
        set_btn(4'b0000);
        cycles(12);

        // Reset mid-debounce abandons the press
        set_btn(B_UP);
        cycles(3);
        rst = 1'b1;
        cycles(2);
        set_btn(4'b0000);
        rst = 1'b0;
        cycles(12);
        tick(1'b0, 10'd320, 10'd448, 1'b0, "rst_debounce");

        // Reset with a hop pending: no carry-over
        press(B_UP);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(2);
        tick(1'b0, 10'd320, 10'd448, 1'b0, "rst_pending");

        // Vector table
        vecs.push_back('{B_UP | B_LEFT, 1'b0, 10'd320, 10'd416, 1'b1});
        vecs.push_back('{4'b0000,       1'b0, 10'd320, 10'd416, 1'b0});
        vecs.push_back('{4'b0000,       1'b1, 10'd320, 10'd448, 1'b0});
        vecs.push_back('{B_DOWN,        1'b0, 10'd320, 10'd448, 1'b0});
        for (int i = 1; i <= 9; i++)
            vecs.push_back('{B_RIGHT, 1'b0, 10'(320 + 32 * i), 10'd448, 1'b1});
        vecs.push_back('{B_RIGHT, 1'b0, wrap ? 10'd0 : 10'd608, 10'd448, wrap});
        vecs.push_back('{B_LEFT,  1'b0, wrap ? 10'd608 : 10'd576, 10'd448, 1'b1});
        vecs.push_back('{4'b0000, 1'b1, 10'd320, 10'd448, 1'b0});
        for (int i = 1; i <= 7; i++)
            vecs.push_back('{B_LEFT, 1'b0, 10'(320 - 32 * i), 10'd448, 1'b1});
        for (int i = 1; i <= 14; i++)
            vecs.push_back('{B_UP, 1'b0, 10'd96, 10'(448 - 32 * i), 1'b1});
        vecs.push_back('{B_UP, 1'b0, 10'd96, 10'd0, 1'b0});

        foreach (vecs[k]) begin
            if (vecs[k].btn != 4'b0000) press(vecs[k].btn);
            tick(vecs[k].rsp, vecs[k].x, vecs[k].y, vecs[k].mv, $sformatf("vec%0d", k));
        end

        // Respawn coincident with tick and a pending up hop at the goal row
        chk("goal_high", 16'(at_goal), 16'd1);
        press(B_UP);
        tick(1'b1, 10'd320, 10'd448, 1'b0, "respawn_tick");
        chk("goal_low", 16'(at_goal), 16'd0);
        tick(1'b0, 10'd320, 10'd448, 1'b0, "after_respawn");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frog_mover.md
# frog_mover

Sequential producer of the frog position consumed by the frog square renderer. Conditions four raw push-buttons (synchronise, debounce, press-edge detect), queues at most one hop per frame, and applies it only on the frame tick so the position never changes mid-scan. Outputs `frog_x`/`frog_y` in pixels, always grid-aligned, feeding the renderer's position inputs directly.

## Interface
- `GRID_SIZE`, 32: hop size in pixels; equals the renderer's square size.
- `H_VISIBLE`, 640: visible width in pixels.
- `V_VISIBLE`, 480: visible height in pixels.
- `START_X`, 320: spawn column in pixels; multiple of `GRID_SIZE`.
- `START_Y`, 448: spawn row in pixels; multiple of `GRID_SIZE`.
- `DEBOUNCE_CYCLES`, 250000: number of stable cycles required to accept a level (10 ms at 25 MHz).
- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-high reset.
- `btn_up` / `btn_down` / `btn_left` / `btn_right` in 1 each: raw, asynchronous, active-high buttons.
- `frame_tick` in 1: one-cycle pulse at the start of vertical blank.
- `respawn` in 1: one-cycle pulse that returns the frog to spawn (collision or goal).
- `frog_x` out 10: frog left edge in pixels.
- `frog_y` out 10: frog top edge in pixels.
- `moved` out 1: one-cycle pulse when the position changed due to a hop.
- `at_goal` out 1: high while `frog_y == 0`.

## Operation
- Button path, per button:
  - 2-flop synchroniser.
  - Debounce counter: reloads to 0 on any change of the synchronised level; commits the level after `DEBOUNCE_CYCLES` stable cycles.
  - Rising edge of the committed level produces a one-cycle press pulse.
- Press pulse sets that direction's pending bit. Holding a button produces one hop only.
- On `frame_tick`:
  - If any pending bit is set, select one direction by priority up > down > left > right.
  - Up: y − `GRID_SIZE`. Down: y + `GRID_SIZE`. Left: x − `GRID_SIZE`. Right: x + `GRID_SIZE`.
  - All pending bits clear, except bits whose press pulse arrives in the same cycle; those remain pending for the next frame.
- Arithmetic uses 11-bit signed intermediates. The legal range is 0..`H_VISIBLE`−`GRID_SIZE` for x (608) and 0..`V_VISIBLE`−`GRID_SIZE` for y (448).
- A hop out of range is discarded: position unchanged, `moved` stays low, pending bits still clear.
- `respawn` loads `START_X`/`START_Y` and clears all pending bits. It overrides a coincident `frame_tick`: no hop, no `moved`.
- `at_goal` is combinational from `frog_y`.

## Timing
- Reset values:
  - `frog_x` = `START_X`, `frog_y` = `START_Y`.
  - `moved` = 0, `at_goal` = 0 (with default `START_Y`).
  - Pending bits, debounce counters and committed levels = 0.
- Press-to-pending latency: 2 (sync) + `DEBOUNCE_CYCLES` + 1 (edge) cycles.
- Pending-to-position latency: position registers update on the clock edge that samples `frame_tick` high. The new position and `moved` are visible in the cycle after the tick.
- `moved` is high for exactly one cycle.
- At most one hop per `frame_tick`.
- Two `frame_tick`s with no intervening press produce no hop.
- Reset asserted mid-debounce or mid-frame abandons all state immediately, with no pending carry-over.

## Configuration
- `FROG_WRAP_EN` defined: horizontal hops wrap. Left from x=0 goes to x=608; right from x=608 goes to x=0; `moved` pulses. Vertical hops remain discard-at-edge.
- `FROG_WRAP_EN` undefined: every out-of-range hop is discarded as described above.

## Structure
- Shared package `frog_pkg`:
  - `GRID_SIZE`, `H_VISIBLE`, `V_VISIBLE` constants, shared with the renderer and the VGA timing block.
  - `dir_t` enum: `DIR_NONE`, `DIR_UP`, `DIR_DOWN`, `DIR_LEFT`, `DIR_RIGHT`.
- Sub-module `button_debouncer`: synchroniser, debounce counter and edge detector, outputting a press pulse. Instantiated four times.
- `frog_mover` itself holds the pending bits, the priority select and the position registers.

## Test plan
Bench uses `DEBOUNCE_CYCLES` = 4.
- Reset, then idle 10 ticks → `frog_x`=320, `frog_y`=448, `moved` never high.
- `btn_up` held 20 cycles, then `frame_tick` → `frog_y`=416, `moved` high 1 cycle. A second tick with the button still held → no change.
- `btn_up` bouncing (toggle every 2 cycles for 12 cycles, then stable high) → exactly one hop on the next tick.
- `btn_left` and `btn_up` pressed in the same frame → tick gives `frog_y`=416, `frog_x`=320. Next tick → no hop (left discarded).
- `btn_down` at y=448 → tick leaves y=448, `moved` low.
- Right press with x=608 → undefined: x stays 608; `FROG_WRAP_EN` defined: x=0, `moved` pulses.
- `respawn` and `frame_tick` coincident with up pending at x=96, y=0 → x=320, y=448, `moved` low, `at_goal` falls.
